// File: rtl/reg_bank_4x4_wq.sv
// reg_bank_4x4_wq: four registers fed through an in-order write queue with per-register pending flags
module reg_bank_4x4_wq #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [1:0]                 wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       commit_en,
    output logic [WIDTH-1:0]           regread0,
    output logic [WIDTH-1:0]           regread1,
    output logic [WIDTH-1:0]           regread2,
    output logic [WIDTH-1:0]           regread3,
    output logic [3:0]                 pending,
    output logic [$clog2(DEPTH+1)-1:0] q_level
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]       q_addr [DEPTH];
    logic [WIDTH-1:0] q_data [DEPTH];
    logic [WIDTH-1:0] regs   [4];
    logic [PW-1:0]    head, tail, head_nxt, tail_nxt;
    logic [CW-1:0]    count;
    logic             push, pop;

    // Ready is a pure function of state so a commit never opens a same-cycle slot
    assign wr_ready = rst_n & (count < CW'(DEPTH));
    assign push     = wr_valid & wr_ready;
    assign pop      = commit_en & (count != '0);
    assign head_nxt = (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
    assign tail_nxt = (tail == PW'(DEPTH - 1)) ? '0 : tail + 1'b1;
    assign q_level  = count;
    assign regread0 = regs[0];
    assign regread1 = regs[1];
    assign regread2 = regs[2];
    assign regread3 = regs[3];

    // Queue payload needs no reset: occupancy alone decides which slots are live
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= wr_addr;
            q_data[tail] <= wr_data;
        end
    end

    // Pointers, occupancy and the bank; commit reads the head before this edge's push lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            if (push) tail <= tail_nxt;
            if (pop) begin
                regs[q_addr[head]] <= q_data[head];
                head <= head_nxt;
            end
            if (push && !pop) count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // A slot is live when its distance from head (mod DEPTH) is below the occupancy
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (((i + DEPTH - int'(head)) % DEPTH) < int'(count)) pending[q_addr[i]] = 1'b1;
    end
endmodule
